// File: rtl/fetch_pkg.sv
// Shared types and instruction field positions for the fetch/decode stage.
package fetch_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_SHL  = 3'b011,
      OP_LDI  = 3'b100,
      OP_STR  = 3'b101,
      OP_BR   = 3'b110,
      OP_HALT = 3'b111
   } opcode_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   localparam int unsigned OPC_MSB  = 8;
   localparam int unsigned OPC_LSB  = 6;
   localparam int unsigned SRC1_MSB = 5;
   localparam int unsigned SRC1_LSB = 3;
   localparam int unsigned SRC2_MSB = 2;
   localparam int unsigned SRC2_LSB = 0;
   localparam int unsigned IMM_W    = 8;

   // ALU ops and LDI produce a register result; STORE, BR and HALT do not.
   function automatic logic op_writes(input opcode_t op);
      return (op <= OP_LDI);
   endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter: start load beats stall, stall beats branch, branch beats increment.
module pc_counter
   import fetch_pkg::*;
#(
   parameter int unsigned PC_W = 10
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            start,
   input  logic [PC_W-1:0] start_pc,
   input  logic            advance,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] branch_target,
   output logic [PC_W-1:0] pc
);

   // advance is low while stalled or outside RUN, so the PC holds.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc <= '0;
      end else if (start) begin
         pc <= start_pc;
      end else if (advance) begin
         if (branch_taken) pc <= branch_target;
         else              pc <= pc + PC_W'(1);
      end
   end

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode stage feeding reg_file and the datapath.
// Optional retired-instruction counter enabled by FETCH_PERF_CNT_EN.
module fetch_decode
   import fetch_pkg::*;
#(
   parameter int unsigned PC_W        = 10,
   parameter int unsigned INSTR_W     = 9,
   parameter int unsigned START_SHIFT = 3
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start,
   input  logic [6:0]         start_address,
   output logic [PC_W-1:0]    instr_addr,
   input  logic [INSTR_W-1:0] instr_data,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [PC_W-1:0]    branch_target,
   output logic               valid,
   output logic [2:0]         opcode,
   output logic [2:0]         src1,
   output logic [2:0]         src2,
   output logic               write,
   output logic [IMM_W-1:0]   imm,
   output logic               halt
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0]        retired_cnt
`endif
);

   state_t          state;
   opcode_t         dec_op;
   logic            is_halt;
   logic            advance;
   logic [PC_W-1:0] start_pc;

   assign dec_op   = opcode_t'(instr_data[OPC_MSB:OPC_LSB]);
   assign is_halt  = (dec_op == OP_HALT);
   assign advance  = (state == RUN) && !stall;
   assign start_pc = PC_W'(32'(start_address) << START_SHIFT);

   pc_counter #(.PC_W(PC_W)) u_pc (
      .clock         (clock),
      .reset_n       (reset_n),
      .start         (start),
      .start_pc      (start_pc),
      .advance       (advance),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .pc            (instr_addr)
   );

   // Control FSM and decode register; a squashed or halting slot never asserts write.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         valid  <= 1'b0;
         opcode <= '0;
         src1   <= '0;
         src2   <= '0;
         write  <= 1'b0;
         imm    <= '0;
         halt   <= 1'b0;
      end else if (start) begin
         state <= RUN;
         valid <= 1'b0;
         write <= 1'b0;
         halt  <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (!stall) begin
                  if (branch_taken) begin
                     valid <= 1'b0;
                     write <= 1'b0;
                  end else begin
                     opcode <= dec_op;
                     src1   <= instr_data[SRC1_MSB:SRC1_LSB];
                     src2   <= instr_data[SRC2_MSB:SRC2_LSB];
                     imm    <= IMM_W'(instr_data[SRC2_MSB:SRC2_LSB]);
                     valid  <= !is_halt;
                     write  <= !is_halt && op_writes(dec_op);
                     if (is_halt) begin
                        state <= HALTED;
                        halt  <= 1'b1;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   // Counts decode slots consumed downstream; saturates rather than wrapping.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         retired_cnt <= '0;
      end else if (start) begin
         retired_cnt <= '0;
      end else if (valid && !stall && (retired_cnt != 16'hFFFF)) begin
         retired_cnt <= retired_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_decode.sv
// Self-checking bench for fetch_decode: scoreboard of per-cycle expectations plus an opcode sweep table.
`timescale 1ns/1ps
module tb_fetch_decode;

   logic       clock;
   logic       reset_n;
   logic       start;
   logic [6:0] start_address;
   logic [9:0] instr_addr;
   logic [8:0] instr_data;
   logic       stall;
   logic       branch_taken;
   logic [9:0] branch_target;
   logic       valid, write, halt;
   logic [2:0] opcode, src1, src2;
   logic [7:0] imm;

   logic       w_start;
   logic [6:0] w_start_address;
   logic [3:0] w_instr_addr;
   logic [8:0] w_instr_data;
   logic       w_branch_taken;
   logic [3:0] w_branch_target;
   logic       w_valid, w_write, w_halt;
   logic [2:0] w_opcode, w_src1, w_src2;
   logic [7:0] w_imm;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0] retired_cnt;
   logic [15:0] w_retired_cnt;
`endif

   logic [8:0] rom [0:1023];
   assign instr_data   = rom[instr_addr];
   assign w_instr_data = 9'b000_000_000;

   int checks = 0;
   int errors = 0;

   fetch_decode dut (
      .clock(clock), .reset_n(reset_n), .start(start), .start_address(start_address),
      .instr_addr(instr_addr), .instr_data(instr_data), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target), .valid(valid),
      .opcode(opcode), .src1(src1), .src2(src2), .write(write), .imm(imm), .halt(halt)
`ifdef FETCH_PERF_CNT_EN
      , .retired_cnt(retired_cnt)
`endif
   );

   fetch_decode #(.PC_W(4)) dut_w (
      .clock(clock), .reset_n(reset_n), .start(w_start), .start_address(w_start_address),
      .instr_addr(w_instr_addr), .instr_data(w_instr_data), .stall(1'b0),
      .branch_taken(w_branch_taken), .branch_target(w_branch_target), .valid(w_valid),
      .opcode(w_opcode), .src1(w_src1), .src2(w_src2), .write(w_write), .imm(w_imm), .halt(w_halt)
`ifdef FETCH_PERF_CNT_EN
      , .retired_cnt(w_retired_cnt)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [9:0] addr;
      logic       valid;
      logic       write;
      logic       halt;
      logic       chk_fields;
      logic [2:0] op;
      logic [2:0] s1;
      logic [2:0] s2;
      logic [7:0] imm;
   } exp_t;

   typedef struct {
      logic [8:0] instr;
      logic       exp_valid;
      logic       exp_write;
      logic       exp_halt;
      logic [2:0] exp_op;
      logic [2:0] exp_s1;
      logic [2:0] exp_s2;
   } vec_t;

   exp_t sb_q[$];

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [9:0] a, input logic v, input logic w, input logic h);
      exp_t e;
      e.addr = a; e.valid = v; e.write = w; e.halt = h;
      e.chk_fields = 1'b0; e.op = '0; e.s1 = '0; e.s2 = '0; e.imm = '0;
      return e;
   endfunction

   function automatic exp_t mkf(input logic [9:0] a, input logic v, input logic w, input logic h,
                                input logic [2:0] op, input logic [2:0] s1, input logic [2:0] s2);
      exp_t e;
      e = mk(a, v, w, h);
      e.chk_fields = 1'b1; e.op = op; e.s1 = s1; e.s2 = s2; e.imm = {5'b0, s2};
      return e;
   endfunction

   // Push the expectation for the coming edge, then compare what the DUT shows after it.
   task automatic step(input string name, input exp_t e);
      exp_t got;
      sb_q.push_back(e);
      @(posedge clock);
      #1;
      got = sb_q.pop_front();
      cmp({name, ".addr"},  32'(instr_addr), 32'(got.addr));
      cmp({name, ".valid"}, 32'(valid),      32'(got.valid));
      cmp({name, ".write"}, 32'(write),      32'(got.write));
      cmp({name, ".halt"},  32'(halt),       32'(got.halt));
      if (got.chk_fields) begin
         cmp({name, ".opcode"}, 32'(opcode), 32'(got.op));
         cmp({name, ".src1"},   32'(src1),   32'(got.s1));
         cmp({name, ".src2"},   32'(src2),   32'(got.s2));
         cmp({name, ".imm"},    32'(imm),    32'(got.imm));
      end
   endtask

   vec_t tbl [8];

   initial begin
      reset_n = 1'b0; start = 1'b0; start_address = '0; stall = 1'b0;
      branch_taken = 1'b0; branch_target = '0;
      w_start = 1'b0; w_start_address = '0; w_branch_taken = 1'b0; w_branch_target = '0;
      for (int i = 0; i < 1024; i++) rom[i] = 9'b000_000_000;

      tbl[0] = '{9'b000_000_111, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 3'd7};
      tbl[1] = '{9'b001_001_110, 1'b1, 1'b1, 1'b0, 3'd1, 3'd1, 3'd6};
      tbl[2] = '{9'b010_010_101, 1'b1, 1'b1, 1'b0, 3'd2, 3'd2, 3'd5};
      tbl[3] = '{9'b011_011_100, 1'b1, 1'b1, 1'b0, 3'd3, 3'd3, 3'd4};
      tbl[4] = '{9'b100_100_011, 1'b1, 1'b1, 1'b0, 3'd4, 3'd4, 3'd3};
      tbl[5] = '{9'b101_101_010, 1'b1, 1'b0, 1'b0, 3'd5, 3'd5, 3'd2};
      tbl[6] = '{9'b110_110_001, 1'b1, 1'b0, 1'b0, 3'd6, 3'd6, 3'd1};
      tbl[7] = '{9'b111_111_000, 1'b0, 1'b0, 1'b1, 3'd7, 3'd7, 3'd0};

      rom[40] = 9'b000_010_001;
      rom[41] = 9'b001_011_100;
      rom[12] = 9'b111_000_000;
      for (int i = 0; i < 8; i++) rom[16 + i] = tbl[i].instr;
      rom[32] = 9'b111_000_000;

      // Reset held through edges, then released with no start: IDLE at address 0.
      step("reset", mkf(10'd0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0));
      reset_n = 1'b1;
      step("idle0", mkf(10'd0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0));
      step("idle1", mkf(10'd0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0));

      start = 1'b1; start_address = 7'd5;
      step("start", mk(10'd40, 1'b0, 1'b0, 1'b0));
      start = 1'b0;
      step("first", mkf(10'd41, 1'b1, 1'b1, 1'b0, 3'd0, 3'd2, 3'd1));

      stall = 1'b1;
      for (int i = 0; i < 3; i++) step("stall", mkf(10'd41, 1'b1, 1'b1, 1'b0, 3'd0, 3'd2, 3'd1));
      branch_taken = 1'b1; branch_target = 10'd100;
      step("stall_br", mkf(10'd41, 1'b1, 1'b1, 1'b0, 3'd0, 3'd2, 3'd1));
      stall = 1'b0;
      step("branch", mk(10'd100, 1'b0, 1'b0, 1'b0));

      branch_target = 10'd12;
      step("br12", mk(10'd12, 1'b0, 1'b0, 1'b0));
      branch_taken = 1'b0;
      step("halt", mk(10'd13, 1'b0, 1'b0, 1'b1));
      branch_target = 10'd200;
      for (int i = 0; i < 4; i++) begin
         stall = i[0]; branch_taken = ~i[1];
         step("halted", mk(10'd13, 1'b0, 1'b0, 1'b1));
      end
      stall = 1'b0; branch_taken = 1'b0;

      start = 1'b1; start_address = 7'd2;
      step("restart", mk(10'd16, 1'b0, 1'b0, 1'b0));
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (tbl[i].exp_halt)
            step("sweep", mk(10'(17 + i), tbl[i].exp_valid, tbl[i].exp_write, tbl[i].exp_halt));
         else
            step("sweep", mkf(10'(17 + i), tbl[i].exp_valid, tbl[i].exp_write, tbl[i].exp_halt,
                              tbl[i].exp_op, tbl[i].exp_s1, tbl[i].exp_s2));
      end
      step("sweep_hold", mk(10'd24, 1'b0, 1'b0, 1'b1));

      // HALT fetched in the same cycle as a branch: branch wins, RUN continues.
      start = 1'b1; start_address = 7'd4;
      step("start32", mk(10'd32, 1'b0, 1'b0, 1'b0));
      start = 1'b0; branch_taken = 1'b1; branch_target = 10'd50;
      step("br_vs_halt", mk(10'd50, 1'b0, 1'b0, 1'b0));
      branch_taken = 1'b0;
      step("after_br", mkf(10'd51, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0));

      // Asynchronous reset mid-cycle, no clock edge in between.
      #3;
      reset_n = 1'b0;
      #1;
      cmp("async.addr",  32'(instr_addr), 32'd0);
      cmp("async.valid", 32'(valid), 32'd0);
      cmp("async.write", 32'(write), 32'd0);
      cmp("async.halt",  32'(halt), 32'd0);
      cmp("async.op",    32'({opcode, src1, src2, imm}), 32'd0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      step("post_rst", mk(10'd0, 1'b0, 1'b0, 1'b0));

      start = 1'b1; start_address = 7'd8;
      step("perf_start", mk(10'd64, 1'b0, 1'b0, 1'b0));
      start = 1'b0;
      for (int i = 0; i < 11; i++) step("perf_run", mk(10'(65 + i), 1'b1, 1'b1, 1'b0));
`ifdef FETCH_PERF_CNT_EN
      cmp("retired_10", 32'(retired_cnt), 32'd10);
`endif
      start = 1'b1;
      step("perf_clr", mk(10'd64, 1'b0, 1'b0, 1'b0));
      start = 1'b0;
`ifdef FETCH_PERF_CNT_EN
      cmp("retired_clr", 32'(retired_cnt), 32'd0);
`endif

      // Narrow PC instance: increment from 15 wraps to 0.
      w_start = 1'b1; w_start_address = 7'd1;
      @(posedge clock); #1;
      cmp("wrap.start", 32'(w_instr_addr), 32'd8);
      w_start = 1'b0; w_branch_taken = 1'b1; w_branch_target = 4'd15;
      @(posedge clock); #1;
      cmp("wrap.br15", 32'(w_instr_addr), 32'd15);
      w_branch_taken = 1'b0;
      @(posedge clock); #1;
      cmp("wrap.zero", 32'(w_instr_addr), 32'd0);
      cmp("wrap.valid", 32'(w_valid), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
